// File: rtl/parallel_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : parallel_cpu_ocimem_arbiter
// Brief   : Shares one single-port debug RAM between CPU Avalon and JTAG OCI-mem
// Revision: 1.0 - initial release
// ============================================================================
module parallel_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_byteen,
    output logic              ram_wren,
    input  logic [31:0]       ram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_jtag_q;
    logic              gnt_jtag_q;
    logic              op_write_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [3:0]        ram_byteen_q;
    logic              ram_wren_q;
    logic [31:0]       avs_rdata_q;
    logic [31:0]       mon_q;
    logic              overrun_q;
    logic [ADDR_W-1:0] jaddr_q;
    logic              pend_valid_q;
    logic              pend_write_q;
    logic [31:0]       pend_wdata_q;

    logic cpu_req;
    logic strobe;
    logic grant_any_d;
    logic grant_jtag_d;
    logic cpu_done;
    logic jtag_done;
    logic unused_jdo;

    assign cpu_req = avs_read | avs_write;
    assign strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    // JTAG wins when alone, when in debug mode, or when the CPU was served last.
    assign grant_any_d  = cpu_req | pend_valid_q;
    assign grant_jtag_d = pend_valid_q & (~cpu_req | debugack | ~last_jtag_q);

    assign cpu_done  = ~gnt_jtag_q & (((state_q == S_ISSUE) & op_write_q) | (state_q == S_DATA));
    assign jtag_done =  gnt_jtag_q & (((state_q == S_ISSUE) & op_write_q) | (state_q == S_DATA));

    assign avs_waitrequest = cpu_req & ~cpu_done;
    assign avs_readdata    = ((state_q == S_DATA) & ~gnt_jtag_q) ? ram_rdata : avs_rdata_q;
    assign MonDReg         = mon_q;
    assign monitor_ready   = ~pend_valid_q;
    assign jtag_overrun    = overrun_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_byteen      = ram_byteen_q;
    assign ram_wren        = ram_wren_q;
    assign unused_jdo      = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_jtag_q  <= 1'b0;
            gnt_jtag_q   <= 1'b0;
            op_write_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_byteen_q <= '0;
            ram_wren_q   <= 1'b0;
            avs_rdata_q  <= '0;
            mon_q        <= '0;
            overrun_q    <= 1'b0;
            jaddr_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            pend_wdata_q <= '0;
        end else begin
            if (jtag_done) begin
                pend_valid_q <= 1'b0;
                jaddr_q      <= jaddr_q + ADDR_ONE;
            end

            // Pending is judged on its registered value, so a strobe on the
            // completion edge still sees it occupied and is dropped.
            if (strobe) begin
                if (pend_valid_q) begin
                    overrun_q <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    jaddr_q <= jdo[10 +: ADDR_W];
                    if (jdo[34]) begin
                        pend_valid_q <= 1'b1;
                        pend_write_q <= 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    pend_valid_q <= 1'b1;
                    pend_write_q <= 1'b0;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_write_q <= 1'b1;
                    pend_wdata_q <= jdo[34:3];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (grant_any_d) begin
                        gnt_jtag_q  <= grant_jtag_d;
                        last_jtag_q <= grant_jtag_d;
                        state_q     <= S_ISSUE;
                        if (grant_jtag_d) begin
                            ram_addr_q   <= jaddr_q;
                            ram_wdata_q  <= pend_wdata_q;
                            ram_byteen_q <= 4'hF;
                            ram_wren_q   <= pend_write_q;
                            op_write_q   <= pend_write_q;
                        end else begin
                            ram_addr_q   <= avs_address;
                            ram_wdata_q  <= avs_writedata;
                            ram_byteen_q <= avs_byteenable;
                            ram_wren_q   <= avs_write;
                            op_write_q   <= avs_write;
                        end
                    end
                end
                S_ISSUE: begin
                    ram_wren_q <= 1'b0;
                    state_q    <= op_write_q ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (gnt_jtag_q) begin
                        mon_q <= ram_rdata;
                    end else begin
                        avs_rdata_q <= ram_rdata;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_parallel_cpu_ocimem_arbiter
// Brief   : Scoreboard bench for the CPU/JTAG debug-RAM arbiter
// Revision: 1.0 - initial release
// ============================================================================
module tb_parallel_cpu_ocimem_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] avs_address = '0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [3:0]        avs_byteenable = '0;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic [37:0]       jdo = '0;
    logic              debugack = 1'b0;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              jtag_overrun;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_byteen;
    logic              ram_wren;
    logic [31:0]       ram_rdata = '0;

    always #5 clk = ~clk;

    parallel_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_byteen              (ram_byteen),
        .ram_wren                (ram_wren),
        .ram_rdata               (ram_rdata)
    );

    // Physical RAM seen by the DUT; ref_mem is the bench's own expectation.
    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= ram[ram_addr];
    end

    int checks   = 0;
    int failures = 0;

    typedef struct { bit rd; logic [31:0] d; } jexp_t;
    typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] be; } wexp_t;

    logic [31:0] cpu_q [$];
    jexp_t       jq    [$];
    wexp_t       wq    [$];

    logic [7:0] m_jaddr     = '0;
    bit         m_last_jtag = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=event", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    logic mr_prev = 1'b1;
    always @(negedge clk) begin : monitor
        int    idx;
        jexp_t je;
        if (reset_n) begin
            if (avs_read && !avs_waitrequest) begin
                if (cpu_q.size() == 0) fail_now("cpu_read_unexpected");
                else check32("cpu_readdata", avs_readdata, cpu_q.pop_front());
            end
            if (monitor_ready && !mr_prev) begin
                if (jq.size() == 0) fail_now("jtag_done_unexpected");
                else begin
                    je = jq.pop_front();
                    if (je.rd) check32("jtag_MonDReg", MonDReg, je.d);
                end
            end
            if (ram_wren) begin
                idx = -1;
                for (int i = 0; i < wq.size(); i++) begin
                    if (idx < 0 && wq[i].a == ram_addr) idx = i;
                end
                if (idx < 0) fail_now("ram_write_unexpected");
                else begin
                    check32("ram_wdata", ram_wdata, wq[idx].d);
                    check32("ram_byteen", {28'd0, ram_byteen}, {28'd0, wq[idx].be});
                    wq.delete(idx);
                end
            end
        end
        mr_prev = monitor_ready;
    end

    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat);
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            wq.push_back('{a, d, be});
        end else begin
            cpu_q.push_back(ref_mem[a]);
        end
        @(posedge clk); #1;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        avs_read = !wr; avs_write = wr;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (lat == 0 && !avs_waitrequest) lat = k;
            if (lat != 0) break;
        end
        if (lat == 0) fail_now("cpu_timeout");
        m_last_jtag = 1'b0;
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    // kind: 0 = take_action_a, 1 = take_no_action_a, 2 = take_action_b
    task automatic jtag_strobe(input int kind, input logic [7:0] a, input logic [31:0] d,
                               input bit rd, input bit drop);
        if (!drop) begin
            case (kind)
                0: begin
                    m_jaddr = a;
                    if (rd) begin jq.push_back('{1'b1, ref_mem[a]}); m_jaddr++; end
                end
                1: begin jq.push_back('{1'b1, ref_mem[m_jaddr]}); m_jaddr++; end
                default: begin
                    ref_mem[m_jaddr] = d;
                    wq.push_back('{m_jaddr, d, 4'hF});
                    jq.push_back('{1'b0, 32'd0});
                    m_jaddr++;
                end
            endcase
        end
        @(posedge clk); #1;
        jdo = '0;
        if (kind == 2) jdo[34:3] = d;
        else begin jdo[17:10] = a; jdo[34] = rd; end
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    endtask

    // Latency counted in cycles from the strobe cycle t.
    task automatic jtag_wait(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (lat == 0 && monitor_ready) lat = k;
            if (lat != 0) break;
        end
        if (lat == 0) fail_now("jtag_timeout");
        m_last_jtag = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_jaddr = '0;
        m_last_jtag = 1'b0;
    endtask

    task automatic tie_test(input logic [7:0] ja, input logic [7:0] ca, input string tag);
        bit jfirst;
        int jl;
        int cl;
        jfirst = debugack || !m_last_jtag;
        fork
            begin jtag_strobe(0, ja, 32'd0, 1'b1, 1'b0); jtag_wait(jl); end
            begin @(posedge clk); cpu_op(1'b0, ca, 32'd0, 4'h0, cl); end
        join
        check32({tag, "_jtag_lat"}, jl, jfirst ? 4 : 7);
        check32({tag, "_cpu_lat"},  cl, jfirst ? 6 : 3);
        m_last_jtag = !jfirst;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = {8'hA5, i[7:0], ~i[7:0], 8'h3C};
            ref_mem[i] = {8'hA5, i[7:0], ~i[7:0], 8'h3C};
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check32("rst_monitor_ready", monitor_ready, 1);
        check32("rst_MonDReg", MonDReg, 0);
        check32("rst_overrun", jtag_overrun, 0);
        check32("rst_readdata", avs_readdata, 0);
        check32("rst_wren", ram_wren, 0);
        check32("rst_ram_addr", ram_addr, 0);

        // Reset asserted while a CPU write sits in ISSUE.
        @(posedge clk); #1;
        avs_address = 8'h20; avs_writedata = 32'hCAFEF00D; avs_byteenable = 4'hF; avs_write = 1'b1;
        @(posedge clk); #2;
        check32("midwrite_wren_before", ram_wren, 1);
        reset_n = 1'b0;
        #1 check32("midwrite_wren_async", ram_wren, 0);
        avs_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        m_jaddr = '0; m_last_jtag = 1'b0;
        @(negedge clk);
        check32("post_rst_monitor_ready", monitor_ready, 1);
        check32("post_rst_MonDReg", MonDReg, 0);
        check32("post_rst_overrun", jtag_overrun, 0);

        cpu_op(1'b1, 8'h10, 32'hDEADBEEF, 4'b0011, lat);
        check32("cpu_write_lat", lat, 2);
        cpu_op(1'b0, 8'h10, 32'd0, 4'h0, lat);
        check32("cpu_read_lat", lat, 3);

        jtag_strobe(0, 8'hFF, 32'd0, 1'b1, 1'b0);
        jtag_wait(lat);
        check32("jtag_read_lat", lat, 4);
        jtag_strobe(1, 8'h00, 32'd0, 1'b0, 1'b0);
        jtag_wait(lat);
        check32("jtag_wrap_read_lat", lat, 4);

        jtag_strobe(2, 8'h00, 32'h12345678, 1'b0, 1'b0);
        jtag_wait(lat);
        check32("jtag_write_lat", lat, 3);
        jtag_strobe(1, 8'h00, 32'd0, 1'b0, 1'b0);
        jtag_wait(lat);
        cpu_op(1'b0, 8'h01, 32'd0, 4'h0, lat);

        // Arbitration ties.
        do_reset();
        debugack = 1'b0;
        tie_test(8'h30, 8'h31, "tie1");
        jtag_strobe(0, 8'h32, 32'd0, 1'b1, 1'b0);
        jtag_wait(lat);
        tie_test(8'h33, 8'h34, "tie2");
        debugack = 1'b1;
        tie_test(8'h35, 8'h36, "tie_dbg");
        debugack = 1'b0;

        // Overrun while pending.
        jtag_strobe(0, 8'h40, 32'd0, 1'b1, 1'b0);
        jtag_strobe(1, 8'h00, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        check32("overrun_set", jtag_overrun, 1);
        jtag_wait(lat);
        jtag_strobe(2, 8'h00, 32'h0BADF00D, 1'b0, 1'b0);
        jtag_wait(lat);
        check32("overrun_sticky", jtag_overrun, 1);

        // Strobe on the completion edge of a JTAG write is also dropped.
        do_reset();
        @(negedge clk);
        check32("overrun_cleared", jtag_overrun, 0);
        jtag_strobe(0, 8'h50, 32'd0, 1'b0, 1'b0);
        jtag_strobe(2, 8'h00, 32'h5A5A5A5A, 1'b0, 1'b0);
        jtag_strobe(1, 8'h00, 32'd0, 1'b0, 1'b1);
        jtag_wait(lat);
        check32("overrun_completion_edge", jtag_overrun, 1);
        repeat (8) @(posedge clk);
        check32("no_extra_jtag_op", jq.size(), 0);

        // Random concurrent traffic on disjoint address halves.
        fork
            begin : cpu_rand
                int l;
                for (int n = 0; n < 30; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    cpu_op($urandom_range(0, 1) == 1, 8'($urandom_range(0, 127)), $urandom,
                           4'($urandom_range(1, 15)), l);
                end
            end
            begin : jtag_rand
                int l;
                int r;
                for (int n = 0; n < 30; n++) begin
                    debugack = ($urandom_range(0, 3) == 0);
                    r = $urandom_range(0, 2);
                    if (r == 0) begin
                        jtag_strobe(0, 8'($urandom_range(128, 255)), 32'd0, 1'b1, 1'b0);
                    end else begin
                        jtag_strobe(0, 8'($urandom_range(128, 254)), 32'd0, 1'b0, 1'b0);
                        jtag_strobe(r == 1 ? 1 : 2, 8'h00, $urandom, 1'b0, 1'b0);
                    end
                    jtag_wait(l);
                end
                debugack = 1'b0;
            end
        join

        repeat (10) @(posedge clk);
        check32("drain_cpu_q", cpu_q.size(), 0);
        check32("drain_jtag_q", jq.size(), 0);
        check32("drain_write_q", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
